// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
//  Package : mem_pkg
//  Shared size codes, RAM lane-select constants, FSM state encoding and the
//  load-extension helpers used by the memory access controller.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input size_e       sz,
                                                input logic        uns);
        logic [31:0] res;
        case (sz)
            SZ_B:    res = {{24{~uns & raw[7]}}, raw[7:0]};
            SZ_H:    res = {{16{~uns & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic res;
        case (sz)
            SZ_H:    res = off[0];
            SZ_W:    res = (off != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Index of the final byte of an access: n-1 for n = 1/2/4.
    function automatic logic [1:0] last_byte(input size_e sz);
        logic [1:0] res;
        case (sz)
            SZ_B:    res = 2'd0;
            SZ_H:    res = 2'd1;
            default: res = 2'd3;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
//  Interface : mem_access_ctrl_if
//  CPU request/response handshake plus the byte-select RAM port.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_uns;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  ram_we;
    logic [3:0]            ram_sel;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_d;
    logic [31:0]           ram_q;

    // Environment side: the CPU pipeline stage plus the RAM itself.
    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, ram_q,
        input  req_ready, resp_valid, resp_rdata, ram_we, ram_sel, ram_addr, ram_d
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, ram_q,
        output req_ready, resp_valid, resp_rdata, ram_we, ram_sel, ram_addr, ram_d
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl_lane_fmt.sv
// ============================================================================
//  Module : mem_lane_fmt
//  Combinational lane formatter: size+offset to lane select, right-justified
//  write data, and lane extraction with sign/zero extension of read data.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_fmt
    import mem_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_off,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_ram_q,
    output logic [3:0]  o_sel,
    output logic [31:0] o_d,
    output logic [31:0] o_rdata
);

    logic [31:0] w_raw;

    always_comb begin
        o_sel = SEL_W;
        o_d   = i_wdata;
        w_raw = i_ram_q;
        case (i_size)
            SZ_B: begin
                o_d = {24'b0, i_wdata[7:0]};
                case (i_off)
                    2'd0: begin o_sel = SEL_B0; w_raw = {24'b0, i_ram_q[7:0]};   end
                    2'd1: begin o_sel = SEL_B1; w_raw = {24'b0, i_ram_q[15:8]};  end
                    2'd2: begin o_sel = SEL_B2; w_raw = {24'b0, i_ram_q[23:16]}; end
                    default: begin o_sel = SEL_B3; w_raw = {24'b0, i_ram_q[31:24]}; end
                endcase
            end
            SZ_H: begin
                o_d = {16'b0, i_wdata[15:0]};
                // Only offsets 0/2 reach here; odd halves are split into bytes upstream.
                if (i_off[1]) begin
                    o_sel = SEL_H1;
                    w_raw = {16'b0, i_ram_q[31:16]};
                end else begin
                    o_sel = SEL_H0;
                    w_raw = {16'b0, i_ram_q[15:0]};
                end
            end
            default: begin
                o_sel = SEL_W;
                o_d   = i_wdata;
                w_raw = i_ram_q;
            end
        endcase
        o_rdata = load_extend(w_raw, i_size, i_uns);
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
//  Module : mem_access_ctrl
//  Load/store controller for the byte-select word RAM: aligned accesses take
//  one RAM cycle, misaligned ones are split into single-byte RAM cycles.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_ctrl_if.slave bus
);

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic                    uns_q, uns_d;
    size_e                   size_q, size_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [1:0]              k_q, k_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [3:0]              sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_d_q, ram_d_d;

    logic                    in_access;
    logic                    misaligned;
    logic                    last;
    logic                    accept;
    logic                    ready;
    logic                    resp;
    logic [ADDR_WIDTH+1:0]   cur_addr;
    logic [7:0]              wbyte;
    logic [DATA_WIDTH-1:0]   assembled;
    size_e                   fmt_size;
    logic                    fmt_uns;
    logic [31:0]             fmt_wdata;
    logic [3:0]              fmt_sel;
    logic [31:0]             fmt_d;
    logic [31:0]             fmt_rdata;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

    assign in_access  = (state_q == ST_ACCESS);
    assign misaligned = is_misaligned(size_q, addr_q[1:0]);
    assign last       = (k_q == last_byte(size_q));
    // Byte address wraps naturally at the top of the aliased space.
    assign cur_addr   = addr_q + (ADDR_WIDTH+2)'(k_q);

    always_comb begin
        wbyte = wdata_q[7:0];
        case (k_q)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    assign fmt_size  = misaligned ? SZ_B : size_q;
    assign fmt_uns   = misaligned ? 1'b1 : uns_q;
    assign fmt_wdata = misaligned ? {24'b0, wbyte} : wdata_q;

    mem_lane_fmt u_lane_fmt (
        .i_size  (fmt_size),
        .i_off   (cur_addr[1:0]),
        .i_uns   (fmt_uns),
        .i_wdata (fmt_wdata),
        .i_ram_q (bus.ram_q),
        .o_sel   (fmt_sel),
        .o_d     (fmt_d),
        .o_rdata (fmt_rdata)
    );

    // Little-endian assembly: byte k of a split load lands in result byte k.
    always_comb begin
        assembled = result_q;
        case (k_q)
            2'd0:    assembled[7:0]   = fmt_rdata[7:0];
            2'd1:    assembled[15:8]  = fmt_rdata[7:0];
            2'd2:    assembled[23:16] = fmt_rdata[7:0];
            default: assembled[31:24] = fmt_rdata[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        uns_d      = uns_q;
        size_d     = size_q;
        addr_d     = addr_q;
        k_d        = k_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        sel_d      = sel_q;
        ram_addr_d = ram_addr_q;
        ram_d_d    = ram_d_q;
        ready      = 1'b0;
        resp       = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready  = 1'b1;
                accept = bus.req_valid;
            end
            ST_ACCESS: begin
                sel_d      = fmt_sel;
                ram_addr_d = cur_addr[ADDR_WIDTH+1:2];
                ram_d_d    = fmt_d;
                if (!misaligned) begin
                    result_d = we_q ? '0 : fmt_rdata;
                    state_d  = ST_DONE;
                end else if (last) begin
                    result_d = we_q ? '0 : load_extend(assembled, size_q, uns_q);
                    state_d  = ST_DONE;
                end else begin
                    result_d = assembled;
                    k_d      = k_q + 2'd1;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                resp    = 1'b1;
                accept  = bus.req_valid;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            we_d    = bus.req_we;
            uns_d   = bus.req_uns;
            size_d  = (bus.req_size == 2'b11) ? SZ_W : size_e'(bus.req_size);
            addr_d  = bus.req_addr[ADDR_WIDTH+1:0];
            wdata_d = bus.req_wdata;
            k_d     = 2'd0;
            state_d = ST_ACCESS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= '0;
            k_q        <= 2'd0;
            wdata_q    <= '0;
            result_q   <= '0;
            sel_q      <= '0;
            ram_addr_q <= '0;
            ram_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            uns_q      <= uns_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            k_q        <= k_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            sel_q      <= sel_d;
            ram_addr_q <= ram_addr_d;
            ram_d_q    <= ram_d_d;
        end
    end

    // RAM port is live only in ACCESS and holds its last value elsewhere;
    // ram_we decodes from state so reset removes it without waiting for a clock.
    assign bus.ram_we     = in_access & we_q;
    assign bus.ram_sel    = in_access ? fmt_sel : sel_q;
    assign bus.ram_addr   = in_access ? cur_addr[ADDR_WIDTH+1:2] : ram_addr_q;
    assign bus.ram_d      = in_access ? fmt_d : ram_d_q;
    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp;
    assign bus.resp_rdata = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
//  Module : tb_mem_access_ctrl
//  Self-checking bench: byte-lane RAM model, vector table and response scoreboard.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int AW = 10;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        logic [3:0]  sel;
        logic [9:0]  raddr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    vec_t        tbl [21];
    exp_t        sb [$];
    exp_t        mon_e;
    logic [3:0]  seq_sel [4];
    logic [9:0]  seq_addr [4];
    logic [31:0] seq_d [4];
    logic [31:0] ram [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: data arrives right-justified and is steered into the selected lanes.
    assign bus.ram_q = ram[bus.ram_addr];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
        end else if (bus.ram_we) begin
            case (bus.ram_sel)
                4'b0001: ram[bus.ram_addr][7:0]   <= bus.ram_d[7:0];
                4'b0010: ram[bus.ram_addr][15:8]  <= bus.ram_d[7:0];
                4'b0100: ram[bus.ram_addr][23:16] <= bus.ram_d[7:0];
                4'b1000: ram[bus.ram_addr][31:24] <= bus.ram_d[7:0];
                4'b0011: ram[bus.ram_addr][15:0]  <= bus.ram_d[15:0];
                4'b1100: ram[bus.ram_addr][31:16] <= bus.ram_d[15:0];
                4'b1111: ram[bus.ram_addr]        <= bus.ram_d;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: actual=resp_valid=1 required=no response");
            end else begin
                mon_e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                chk("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_size  = v.size;
        bus.req_uns   = v.uns;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
    endtask

    task automatic wait_resp();
        int guard = 0;
        while (sb.size() != 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: actual=%0d pending required=0 pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout vec %0d: actual=req_ready=0 required=1", idx);
            return;
        end
        drive(v);
        sb.push_back('{v.exp, cyc, v.lat});
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk($sformatf("v%0d_ram_we", idx), 32'(bus.ram_we), 32'(v.we));
        chk($sformatf("v%0d_ram_sel", idx), 32'(bus.ram_sel), 32'(v.sel));
        chk($sformatf("v%0d_ram_addr", idx), 32'(bus.ram_addr), 32'(v.raddr));
        wait_resp();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_uns   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        //            we    size   uns   addr          wdata          exp            lat sel      raddr
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h00000010, 32'h11223344, 32'h00000000, 2, 4'b1111, 10'h004};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h00000010, 32'h00000000, 32'h11223344, 2, 4'b1111, 10'h004};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h00000013, 32'hFFFFFF80, 32'h00000000, 2, 4'b1000, 10'h004};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h00000013, 32'h00000000, 32'hFFFFFF80, 2, 4'b1000, 10'h004};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h00000013, 32'h00000000, 32'h00000080, 2, 4'b1000, 10'h004};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h00000022, 32'h5555BEEF, 32'h00000000, 2, 4'b1100, 10'h008};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h00000022, 32'h00000000, 32'hFFFFBEEF, 2, 4'b1100, 10'h008};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h00000022, 32'h00000000, 32'h0000BEEF, 2, 4'b1100, 10'h008};
        tbl[8]  = '{1'b0, 2'd2, 1'b1, 32'h00000005, 32'h00000000, 32'hAABBCCDD, 5, 4'b0010, 10'h001};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00001234, 32'h00000000, 3, 4'b1000, 10'h3FF};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00001234, 3, 4'b1000, 10'h3FF};
        tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h00000FFF, 32'h00000000, 32'h00001234, 3, 4'b1000, 10'h3FF};
        tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h00000021, 32'h00000000, 32'hFFFFEF00, 3, 4'b0010, 10'h008};
        tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h00000010, 32'h00000000, 32'h80223344, 2, 4'b1111, 10'h004};
        tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h00000012, 32'h00000000, 32'hFFFF8022, 2, 4'b1100, 10'h004};
        tbl[15] = '{1'b0, 2'd3, 1'b0, 32'h00000010, 32'h00000000, 32'h80223344, 2, 4'b1111, 10'h004};
        tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h00000011, 32'h00000000, 32'h00802233, 5, 4'b0010, 10'h004};
        tbl[17] = '{1'b0, 2'd0, 1'b1, 32'h00001000, 32'h00000000, 32'h00000012, 2, 4'b0001, 10'h000};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 32'h00000007, 32'h00000000, 32'hFFFFFFBB, 2, 4'b1000, 10'h001};
        tbl[19] = '{1'b0, 2'd0, 1'b1, 32'h00000008, 32'h00000000, 32'h000000AA, 2, 4'b0001, 10'h002};
        tbl[20] = '{1'b0, 2'd2, 1'b0, 32'h00000FFE, 32'h00000000, 32'h00123400, 5, 4'b0100, 10'h3FF};

        seq_sel[0] = 4'b0010; seq_addr[0] = 10'h001; seq_d[0] = 32'h000000DD;
        seq_sel[1] = 4'b0100; seq_addr[1] = 10'h001; seq_d[1] = 32'h000000CC;
        seq_sel[2] = 4'b1000; seq_addr[2] = 10'h001; seq_d[2] = 32'h000000BB;
        seq_sel[3] = 4'b0001; seq_addr[3] = 10'h002; seq_d[3] = 32'h000000AA;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_sel", 32'(bus.ram_sel), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_d", bus.ram_d, 32'd0);
        clr = 1'b0;
        rst = 1'b0;

        // Misaligned word store: four byte cycles walking into the next word
        @(negedge clk);
        drive('{1'b1, 2'd2, 1'b0, 32'h00000005, 32'hAABBCCDD, 32'h0, 5, 4'b0010, 10'h001});
        sb.push_back('{32'h00000000, cyc, 5});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk($sformatf("mis_we_k%0d", k), 32'(bus.ram_we), 32'd1);
            chk($sformatf("mis_sel_k%0d", k), 32'(bus.ram_sel), 32'(seq_sel[k]));
            chk($sformatf("mis_addr_k%0d", k), 32'(bus.ram_addr), 32'(seq_addr[k]));
            chk($sformatf("mis_d_k%0d", k), bus.ram_d, seq_d[k]);
        end
        wait_resp();

        // Reset during the second byte cycle of the same store
        @(negedge clk);
        drive('{1'b1, 2'd2, 1'b0, 32'h00000005, 32'hAABBCCDD, 32'h0, 5, 4'b0010, 10'h001});
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_we_before", 32'(bus.ram_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_async", 32'(bus.ram_we), 32'd0);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("abort_idle_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 21; i++) run_vec(i, tbl[i]);

        // Back-to-back aligned loads: second accepted in DONE
        @(negedge clk);
        drive('{1'b0, 2'd2, 1'b0, 32'h00000010, 32'h0, 32'h0, 2, 4'b1111, 10'h004});
        sb.push_back('{32'h80223344, cyc, 2});
        @(negedge clk);
        chk("b2b_ready_busy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_done", 32'(bus.req_ready), 32'd1);
        sb.push_back('{32'h80223344, cyc, 2});
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_resp();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
